// File: rtl/gray_ptr_ctrl.sv
// Per-domain async FIFO pointer controller: binary/Gray pointer pair plus full-or-empty,
// almost flag and fill level computed against the synchronised remote Gray pointer.
module gray_ptr_ctrl #(
    parameter int ADDR_WIDTH    = 4,
    parameter int MODE          = 0,
    parameter int ALMOST_THRESH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  inc_i,
    input  logic [ADDR_WIDTH:0]   sync_ptr_i,
    output logic                  accept_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [ADDR_WIDTH:0]   bin_ptr_o,
    output logic [ADDR_WIDTH:0]   gray_ptr_o,
    output logic                  flag_o,
    output logic                  almost_o,
    output logic [ADDR_WIDTH:0]   level_o
);
    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int LIMIT = (DEPTH > ALMOST_THRESH) ? (DEPTH - ALMOST_THRESH) : 0;

    localparam logic [PW-1:0] FULL_LIMIT = PW'(LIMIT);
    localparam logic [PW-1:0] THRESH_P   = PW'(ALMOST_THRESH);
    localparam logic          RST_FLAG   = (MODE != 0);
    localparam logic          RST_ALMOST = (MODE != 0) || (ALMOST_THRESH >= DEPTH);

    logic [PW-1:0] bin_next;
    logic [PW-1:0] gray_next;
    logic [PW-1:0] sync_bin;
    logic [PW-1:0] full_cmp;
    logic [PW-1:0] level_next;
    logic          flag_next;
    logic          almost_next;

    assign accept_o  = inc_i & ~flag_o & ~rst_i;
    assign bin_next  = bin_ptr_o + PW'(accept_o);
    assign gray_next = bin_next ^ (bin_next >> 1);
    assign addr_o    = bin_ptr_o[ADDR_WIDTH-1:0];

    // Each binary bit is the XOR of all Gray bits at and above it.
    always_comb begin
        sync_bin = '0;
        for (int i = 0; i < PW; i++) begin
            sync_bin[i] = ^(sync_ptr_i >> i);
        end
    end

    // Full when the pointers differ only in wrap bit: in Gray that flips the top two bits.
    assign full_cmp = {~sync_ptr_i[PW-1:PW-2], sync_ptr_i[PW-3:0]};

    always_comb begin
        if (MODE == 0) begin
            flag_next   = (gray_next == full_cmp);
            level_next  = bin_next - sync_bin;
            almost_next = (level_next >= FULL_LIMIT);
        end else begin
            flag_next   = (gray_next == sync_ptr_i);
            level_next  = sync_bin - bin_next;
            almost_next = (level_next <= THRESH_P);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bin_ptr_o  <= '0;
            gray_ptr_o <= '0;
            level_o    <= '0;
            flag_o     <= RST_FLAG;
            almost_o   <= RST_ALMOST;
        end else begin
            bin_ptr_o  <= bin_next;
            gray_ptr_o <= gray_next;
            level_o    <= level_next;
            flag_o     <= flag_next;
            almost_o   <= almost_next;
        end
    end
endmodule

// File: tb/tb_gray_ptr_ctrl.sv
// Bench for gray_ptr_ctrl: write side (thresh 2), read side (thresh 2) and write side
// (thresh 0) run in lockstep against an occupancy-based reference model.
module tb_gray_ptr_ctrl;
    localparam int MODE_T [3] = '{0, 1, 0};
    localparam int THR_T  [3] = '{2, 2, 0};

    logic       clk = 1'b0;
    logic       rst;
    logic       inc   [3];
    logic [4:0] sync  [3];
    logic       acc   [3];
    logic [3:0] addr  [3];
    logic [4:0] bin   [3];
    logic [4:0] gray  [3];
    logic       flag  [3];
    logic       alm   [3];
    logic [4:0] lvl   [3];

    int   checks = 0;
    int   errors = 0;
    int   m_bin  [3];
    int   r      [3];
    int   m_lvl  [3];
    bit   m_flag [3];
    bit   m_alm  [3];
    bit   e_acc  [3];
    logic [4:0] prev_gray [3];
    int   n_acc;

    always #5 clk = ~clk;

    gray_ptr_ctrl #(.ADDR_WIDTH(4), .MODE(0), .ALMOST_THRESH(2)) dut_w (
        .clk_i(clk), .rst_i(rst), .inc_i(inc[0]), .sync_ptr_i(sync[0]),
        .accept_o(acc[0]), .addr_o(addr[0]), .bin_ptr_o(bin[0]), .gray_ptr_o(gray[0]),
        .flag_o(flag[0]), .almost_o(alm[0]), .level_o(lvl[0]));

    gray_ptr_ctrl #(.ADDR_WIDTH(4), .MODE(1), .ALMOST_THRESH(2)) dut_r (
        .clk_i(clk), .rst_i(rst), .inc_i(inc[1]), .sync_ptr_i(sync[1]),
        .accept_o(acc[1]), .addr_o(addr[1]), .bin_ptr_o(bin[1]), .gray_ptr_o(gray[1]),
        .flag_o(flag[1]), .almost_o(alm[1]), .level_o(lvl[1]));

    gray_ptr_ctrl #(.ADDR_WIDTH(4), .MODE(0), .ALMOST_THRESH(0)) dut_w0 (
        .clk_i(clk), .rst_i(rst), .inc_i(inc[2]), .sync_ptr_i(sync[2]),
        .accept_o(acc[2]), .addr_o(addr[2]), .bin_ptr_o(bin[2]), .gray_ptr_o(gray[2]),
        .flag_o(flag[2]), .almost_o(alm[2]), .level_o(lvl[2]));

    task automatic check(input string tag, input int k, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    // One clock: drive remote pointers, check accept, clock, advance model, check outputs.
    task automatic tick();
        for (int k = 0; k < 3; k++) begin
            sync[k]  = 5'((r[k] ^ (r[k] >> 1)) & 31);
            e_acc[k] = inc[k] && !m_flag[k] && !rst;
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            check("accept", k, 32'(acc[k]), 32'(e_acc[k]));
            prev_gray[k] = gray[k];
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_bin[k]  = 0;
                m_lvl[k]  = 0;
                m_flag[k] = (MODE_T[k] != 0);
                m_alm[k]  = (MODE_T[k] != 0) || (THR_T[k] >= 16);
            end else begin
                if (e_acc[k]) m_bin[k] = (m_bin[k] + 1) % 32;
                if (MODE_T[k] == 0) begin
                    m_lvl[k]  = (m_bin[k] - r[k] + 32) % 32;
                    m_flag[k] = (m_lvl[k] == 16);
                    m_alm[k]  = (m_lvl[k] >= 16 - THR_T[k]);
                end else begin
                    m_lvl[k]  = (r[k] - m_bin[k] + 32) % 32;
                    m_flag[k] = (m_lvl[k] == 0);
                    m_alm[k]  = (m_lvl[k] <= THR_T[k]);
                end
                check("gray_step", k, 32'($countones(prev_gray[k] ^ gray[k])), 32'(e_acc[k]));
            end
            check("bin_ptr", k, 32'(bin[k]), 32'(m_bin[k]));
            check("addr", k, 32'(addr[k]), 32'(m_bin[k] % 16));
            check("gray_ptr", k, 32'(gray[k]), 32'(m_bin[k] ^ (m_bin[k] >> 1)));
            check("level", k, 32'(lvl[k]), 32'(m_lvl[k]));
            check("flag", k, 32'(flag[k]), 32'(m_flag[k]));
            check("almost", k, 32'(alm[k]), 32'(m_alm[k]));
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            inc[k] = 1'b0;
            r[k]   = 0;
            m_flag[k] = 1'b0;
        end
        inc[0] = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        inc[0] = 1'b0;
        tick();

        // Fill both write sides to 16; read side sees remote at 3 and drains it.
        inc[0] = 1'b1;
        inc[2] = 1'b1;
        r[1]   = 3;
        for (int i = 0; i < 16; i++) begin
            if (i == 1) inc[1] = 1'b1;
            if (i == 4) inc[1] = 1'b0;
            tick();
        end
        check("full_flag", 0, 32'(flag[0]), 32'd1);
        check("full_gray", 0, 32'(gray[0]), 32'b11000);
        check("full_level", 0, 32'(lvl[0]), 32'd16);
        check("thresh0_almost", 2, 32'(alm[2]), 32'd1);
        check("empty_flag", 1, 32'(flag[1]), 32'd1);
        check("empty_gray", 1, 32'(gray[1]), 32'b00010);
        tick();
        check("dropped_inc", 0, 32'(bin[0]), 32'd16);

        // Remote read releases full without local activity.
        inc[0] = 1'b0;
        r[0]   = 1;
        tick();
        check("release_flag", 0, 32'(flag[0]), 32'd0);
        check("release_level", 0, 32'(lvl[0]), 32'd15);
        inc[0] = 1'b1;
        tick();

        // Wrap: 64 accepts on dut_w with the remote pointer keeping pace.
        n_acc = 0;
        for (int i = 0; i < 80 && n_acc < 64; i++) begin
            for (int k = 0; k < 3; k++) begin
                inc[k] = 1'b1;
                r[k]   = (r[k] + 1) % 32;
            end
            tick();
            if (e_acc[0]) n_acc++;
        end
        check("wrap_accepts", 0, 32'(n_acc), 32'd64);

        // Reset mid-fill with inc held high.
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            inc[k] = 1'b0;
            r[k]   = 0;
        end
        tick();
        rst = 1'b0;
        inc[0] = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        check("pre_reset_bin", 0, 32'(bin[0]), 32'd9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("restart_bin", 0, 32'(bin[0]), 32'd1);

        // Random traffic with legal remote pointer movement.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 3; k++) begin
                inc[k] = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 1) == 1) begin
                    if (MODE_T[k] == 0) begin
                        if ((m_bin[k] - r[k] + 32) % 32 > 0) r[k] = (r[k] + 1) % 32;
                    end else begin
                        if ((r[k] - m_bin[k] + 32) % 32 < 16) r[k] = (r[k] + 1) % 32;
                    end
                end
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
